// File: rtl/router_output_scheduler_if.sv
// router_output_scheduler_if: request/grant/credit bundle between router inputs and one output scheduler
interface router_output_scheduler_if #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS-1:0]   req;
  logic [NUM_INPUTS-1:0]   req_is_tail;
  logic [NUM_INPUTS-1:0]   turn_disable;
  logic                    credit_in;
  logic [NUM_INPUTS-1:0]   grant;
  logic [IDX_WIDTH-1:0]    owner_idx;
  logic                    locked;
  logic                    send_out;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    credit_err;
  modport master (
    output req, req_is_tail, turn_disable, credit_in,
    input  grant, owner_idx, locked, send_out, credits, credit_err
  );
  modport slave (
    input  req, req_is_tail, turn_disable, credit_in,
    output grant, owner_idx, locked, send_out, credits, credit_err
  );
endinterface

// File: rtl/router_output_scheduler.sv
// router_output_scheduler: round-robin wormhole arbiter for one output link with downstream credit gating
module router_output_scheduler #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                     clk_noc,
  input  logic                     rst_noc_sync,
  router_output_scheduler_if.slave bus
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                  state, state_next;
  logic [IDX_WIDTH-1:0]    owner_q, rr_ptr, winner;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic [NUM_INPUTS-1:0]   eligible;
  logic                    err_q, send, sat;
  always_comb begin
    int j;
    j = 0;
    eligible = bus.req & ~bus.turn_disable;
    winner = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      j = int'(rr_ptr) + k;
      j = j >= NUM_INPUTS ? j - NUM_INPUTS : j;
      winner = eligible[j] ? IDX_WIDTH'(j) : winner;
    end
    send = state == LOCKED && bus.req[owner_q] && credits_q != '0;
    sat = bus.credit_in && !send && credits_q == CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    state_next = state == IDLE ? (|eligible ? LOCKED : IDLE)
                               : (send && bus.req_is_tail[owner_q] ? IDLE : LOCKED);
  end
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state     <= IDLE;
      owner_q   <= '0;
      rr_ptr    <= IDX_WIDTH'(NUM_INPUTS - 1);
      credits_q <= CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      owner_q   <= state == IDLE && |eligible ? winner : owner_q;
      rr_ptr    <= state == LOCKED && state_next == IDLE ? owner_q : rr_ptr;
      credits_q <= sat ? credits_q : credits_q + CREDIT_WIDTH'(bus.credit_in) - CREDIT_WIDTH'(send);
      err_q     <= err_q | sat;
    end
  end
  assign bus.grant      = state == LOCKED ? NUM_INPUTS'(1) << owner_q : '0;
  assign bus.locked     = state == LOCKED;
  assign bus.owner_idx  = owner_q;
  assign bus.send_out   = send;
  assign bus.credits    = credits_q;
  assign bus.credit_err = err_q;
endmodule

// File: tb/tb_router_output_scheduler.sv
// tb_router_output_scheduler: directed and random checks of the output scheduler against a cycle model
module tb_router_output_scheduler;
  localparam int N = 5;
  localparam int D = 8;
  logic clk_noc = 1'b0;
  logic rst_noc_sync;
  always #5 clk_noc = ~clk_noc;
  router_output_scheduler_if #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(D)) bus ();
  router_output_scheduler #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(D)) dut (
    .clk_noc(clk_noc),
    .rst_noc_sync(rst_noc_sync),
    .bus(bus.slave)
  );
  int n_cmp = 0;
  int n_fail = 0;
  int m_owner, m_ptr, m_cred;
  bit m_err;
  bit m_valid = 1'b0;
  bit auto_credit = 1'b0;
  int left[N];
  int plen[N];
  int sends[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int new_len(input int i);
    return plen[i] > 0 ? plen[i] : int'($urandom_range(1, 4));
  endfunction
  task automatic cycle();
    bit s, t;
    for (int i = 0; i < N; i++) bus.req_is_tail[i] = (left[i] == 1);
    s = m_valid && m_owner >= 0 && bus.req[m_owner] && m_cred > 0;
    if (auto_credit) bus.credit_in = s;
    @(negedge clk_noc);
    if (m_valid) begin
      chk("locked", 32'(bus.locked), 32'(m_owner >= 0));
      chk("grant", 32'(bus.grant), m_owner >= 0 ? 32'(1) << m_owner : 32'(0));
      chk("send_out", 32'(bus.send_out), 32'(s));
      chk("credits", 32'(bus.credits), m_cred);
      chk("credit_err", 32'(bus.credit_err), 32'(m_err));
      if (m_owner >= 0) chk("owner_idx", 32'(bus.owner_idx), m_owner);
    end
    if (bus.send_out === 1'b1) sends.push_back(int'(bus.grant));
    @(posedge clk_noc);
    if (rst_noc_sync) begin
      m_owner = -1;
      m_ptr = N - 1;
      m_cred = D;
      m_err = 1'b0;
      m_valid = 1'b1;
      for (int i = 0; i < N; i++) left[i] = new_len(i);
    end else if (m_valid) begin
      t = m_owner >= 0 ? bus.req_is_tail[m_owner] : 1'b0;
      if (s) begin
        left[m_owner]--;
        if (left[m_owner] == 0) left[m_owner] = new_len(m_owner);
      end
      m_cred = m_cred - int'(s) + int'(bus.credit_in);
      if (m_cred > D) begin
        m_cred = D;
        m_err = 1'b1;
      end
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (bus.req[(m_ptr + k) % N] && !bus.turn_disable[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
      end else if (s && t) begin
        m_ptr = m_owner;
        m_owner = -1;
      end
    end
    #1;
  endtask
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic do_reset();
    rst_noc_sync = 1'b1;
    cycle();
    rst_noc_sync = 1'b0;
  endtask
  initial begin
    rst_noc_sync = 1'b0;
    bus.req = '0;
    bus.req_is_tail = '0;
    bus.turn_disable = '0;
    bus.credit_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      plen[i] = 1;
      left[i] = 1;
    end
    #2;
    do_reset();
    chk("rst_credits", 32'(bus.credits), 8);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_send", 32'(bus.send_out), 0);
    chk("rst_err", 32'(bus.credit_err), 0);
    plen[0] = 3;
    left[0] = 3;
    auto_credit = 1'b1;
    sends.delete();
    bus.req = 5'b00001;
    cycles(4);
    bus.req = '0;
    cycle();
    chk("t1_sends", sends.size(), 3);
    chk("t1_locked", 32'(bus.locked), 0);
    chk("t1_credits", 32'(bus.credits), 8);
    sends.delete();
    bus.req = 5'b10110;
    cycles(12);
    bus.req = '0;
    cycles(2);
    chk("t2_s0", sends[0], 2);
    chk("t2_s1", sends[1], 4);
    chk("t2_s2", sends[2], 16);
    chk("t2_s3", sends[3], 2);
    chk("t2_s4", sends[4], 4);
    chk("t2_s5", sends[5], 16);
    auto_credit = 1'b0;
    bus.credit_in = 1'b0;
    plen[3] = 10;
    left[3] = 10;
    bus.req = 5'b01000;
    cycles(9);
    chk("t3_cred0", 32'(bus.credits), 0);
    cycles(2);
    chk("t3_stall_send", 32'(bus.send_out), 0);
    chk("t3_stall_grant", 32'(bus.grant), 5'b01000);
    bus.credit_in = 1'b1;
    cycle();
    bus.credit_in = 1'b0;
    chk("t3_resume", 32'(bus.send_out), 1);
    cycle();
    chk("t3_cred_back0", 32'(bus.credits), 0);
    bus.credit_in = 1'b1;
    cycles(2);
    bus.credit_in = 1'b0;
    bus.req = '0;
    cycle();
    do_reset();
    plen[0] = 2;
    bus.turn_disable = 5'b00100;
    bus.req = 5'b00100;
    cycles(4);
    chk("t4_blocked", 32'(bus.locked), 0);
    left[0] = 2;
    bus.req = 5'b00101;
    cycle();
    chk("t4_locked", 32'(bus.locked), 1);
    chk("t4_owner", 32'(bus.owner_idx), 0);
    auto_credit = 1'b1;
    cycles(3);
    bus.req = '0;
    bus.turn_disable = '0;
    auto_credit = 1'b0;
    do_reset();
    plen[2] = 10;
    left[2] = 10;
    bus.req = 5'b00100;
    cycles(4);
    chk("t5_cred5", 32'(bus.credits), 5);
    chk("t5_mid", 32'(bus.owner_idx), 2);
    do_reset();
    chk("t5_locked", 32'(bus.locked), 0);
    chk("t5_grant", 32'(bus.grant), 0);
    chk("t5_credits", 32'(bus.credits), 8);
    chk("t5_err", 32'(bus.credit_err), 0);
    bus.req = 5'b00101;
    cycle();
    chk("t5_winner", 32'(bus.owner_idx), 0);
    bus.req = 5'b00001;
    auto_credit = 1'b1;
    cycles(3);
    bus.req = '0;
    auto_credit = 1'b0;
    do_reset();
    bus.credit_in = 1'b1;
    cycle();
    bus.credit_in = 1'b0;
    chk("t6_sat", 32'(bus.credits), 8);
    chk("t6_err", 32'(bus.credit_err), 1);
    cycles(2);
    chk("t6_sticky", 32'(bus.credit_err), 1);
    plen[1] = 10;
    left[1] = 10;
    bus.req = 5'b00010;
    cycles(6);
    chk("t6_cred3", 32'(bus.credits), 3);
    bus.credit_in = 1'b1;
    cycle();
    bus.credit_in = 1'b0;
    chk("t6_same_cycle", 32'(bus.credits), 3);
    for (int i = 0; i < N; i++) plen[i] = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.req = N'($urandom);
      bus.turn_disable = N'($urandom & $urandom & $urandom);
      bus.credit_in = $urandom_range(0, 2) == 0;
      rst_noc_sync = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst_noc_sync = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
